alu_decode_mdu: RTL and testbench

//  Second-generation ALU decoder for the RV32 core: decodes Aluop/funct3/funct7 into a 4-bit ALU control
//  for single-cycle ops and also runs RV32M MUL/DIV/REM on an iterative, multi-cycle unit. It sits between
//  the main decoder and the execute stage. While an M-op is in flight it raises stall to hold the core.

---
 rtl/alu_decode_mdu_pkg.sv | 53 +++++
 rtl/alu_decode_mdu_iter.sv | 134 +++++++++++++
 rtl/alu_decode_mdu.sv | 80 ++++++++
 tb/tb_alu_decode_mdu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_mdu_pkg.sv
// Shared types for the ALU decoder and its iterative multiply/divide unit.
// Holds ALU control codes, M-op encoding, MDU state encoding and funct7 constants.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLL   = 4'b0110,
        ALU_SLTU  = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_t;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_signed_b(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/alu_decode_mdu_iter.sv
// Iterative RV32M unit: magnitude shift-add multiply / restoring divide, sign fixed up at the end.
// Latency: start accepted at edge E, done asserted in the cycle after edge E+XLEN+1.
// Backpressure: none; start is ignored outside IDLE, flush returns to IDLE on the next edge.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    mdu_state_t      state, state_nx;
    logic [CW-1:0]   count;
    mdu_op_t         op_q;
    logic [XLEN-1:0] mag_a, mag_b, hi, lo;
    logic            res_neg, rem_neg, div_zero;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   mul_sum, div_r;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem, fin;

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = MDU_IDLE;
        end else begin
            case (state)
                MDU_IDLE: if (start) state_nx = MDU_CALC;
                MDU_CALC: if (count == LAST) state_nx = MDU_DONE;
                default:  state_nx = MDU_IDLE;
            endcase
        end
    end

    always_comb begin
        a_neg = op_signed_a(op) & a[XLEN-1];
        b_neg = op_signed_b(op) & b[XLEN-1];
        a_abs = a_neg ? -a : a;
        b_abs = b_neg ? -b : b;
    end

    // {hi,lo} is the product register for multiply and {remainder,quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
        div_r    = {hi, lo[XLEN-1]};
        div_ge   = div_r >= {1'b0, mag_b};
        div_diff = div_r[XLEN-1:0] - mag_b;
    end

    always_comb begin
        prod = {hi, lo};
        if (res_neg) prod = -prod;
        quo = res_neg ? -lo : lo;
        if (div_zero) quo = '1;
        rem = div_zero ? mag_a : hi;
        if (rem_neg) rem = -rem;
        case (op_q)
            MDU_MUL:                        fin = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fin = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fin = quo;
            default:                        fin = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MDU_IDLE;
            count    <= '0;
            op_q     <= MDU_MUL;
            mag_a    <= '0;
            mag_b    <= '0;
            hi       <= '0;
            lo       <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                count <= '0;
            end else begin
                case (state)
                    MDU_IDLE: if (start) begin
                        op_q     <= op;
                        mag_a    <= a_abs;
                        mag_b    <= b_abs;
                        hi       <= '0;
                        lo       <= op_is_div(op) ? a_abs : b_abs;
                        res_neg  <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        div_zero <= (b == '0);
                        count    <= '0;
                    end
                    MDU_CALC: begin
                        if (count != LAST) begin
                            count <= count + 1'b1;
                            if (op_is_div(op_q)) begin
                                hi <= div_ge ? div_diff : div_r[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], div_ge};
                            end else begin
                                hi <= mul_sum[XLEN:1];
                                lo <= {mul_sum[0], lo[XLEN-1:1]};
                            end
                        end else begin
                            result <= fin;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == MDU_CALC);
    assign done = (state == MDU_DONE) & ~flush;

endmodule

// File: rtl/alu_decode_mdu.sv
// ALU control decode for single-cycle ops plus RV32M dispatch to the iterative unit.
// Latency: decode is combinational; M-op result pulses XLEN+1 cycles after the accept edge.
// Backpressure: stall holds the core while an M-op is requested or computing; flush drops it at once.
module alu_decode_mdu
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      aluop,
    input  logic            op5,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      alu_ctrl,
    output logic            illegal,
    output logic            stall,
    output logic            mdu_valid,
    output logic [XLEN-1:0] mdu_result
);

    alu_ctrl_t ctrl;
    logic      f7_legal, mdu_req, busy, done;

    assign f7_legal = (funct7 == FUNCT7_BASE) ||
                      ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                      ((funct7 == FUNCT7_MULDIV) && MDU_EN);

    always_comb begin
        ctrl    = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            2'b00: ctrl = ALU_ADD;
            2'b01: ctrl = ALU_SUB;
            2'b11: ctrl = ALU_PASSB;
            default: begin
                case (funct3)
                    3'b000:  ctrl = (op5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
                if (op5 && !f7_legal) begin
                    illegal = 1'b1;
                    ctrl    = ALU_ADD;
                end
            end
        endcase
    end

    assign alu_ctrl = ctrl;
    assign mdu_req  = in_valid && (aluop == 2'b10) && op5 && (funct7 == FUNCT7_MULDIV) && MDU_EN;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_req),
        .flush  (flush),
        .op     (mdu_op_t'(funct3)),
        .a      (rs1),
        .b      (rs2),
        .busy   (busy),
        .done   (done),
        .result (mdu_result)
    );

    // A request seen while DONE is the instruction just retiring, so it must not stall.
    assign stall     = ~flush & (busy | (mdu_req & ~done));
    assign mdu_valid = done;

endmodule

// File: tb/tb_alu_decode_mdu.sv
// Bench for alu_decode_mdu: arithmetic reference model with per-cycle compare, directed and random stimulus.
module tb_alu_decode_mdu;
    localparam int XLEN   = 32;
    localparam bit MDU_EN = 1'b1;

    logic            clk, rst_n, in_valid, op5, flush;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1, rs2;
    logic [3:0]      alu_ctrl;
    logic            illegal, stall, mdu_valid;
    logic [XLEN-1:0] mdu_result;

    alu_decode_mdu #(.XLEN(XLEN), .MDU_EN(MDU_EN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aluop(aluop), .op5(op5),
        .funct3(funct3), .funct7(funct7), .flush(flush), .rs1(rs1), .rs2(rs2),
        .alu_ctrl(alu_ctrl), .illegal(illegal), .stall(stall),
        .mdu_valid(mdu_valid), .mdu_result(mdu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: decode table and RV32M arithmetic on wide signed integers.
    function automatic logic ref_illegal(input logic [1:0] ao, input logic o5,
                                         input logic [2:0] f3, input logic [6:0] f7);
        if (ao != 2'b10 || !o5) return 1'b0;
        if (f7 == 7'h00) return 1'b0;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 1'b0;
        if (f7 == 7'h01 && MDU_EN) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [1:0] ao, input logic o5,
                                            input logic [2:0] f3, input logic [6:0] f7);
        if (ref_illegal(ao, o5, f3, f7)) return 4'd0;
        case (ao)
            2'd0: return 4'd0;
            2'd1: return 4'd1;
            2'd3: return 4'd10;
            default: case (f3)
                3'd0: return (o5 && f7[5]) ? 4'd1 : 4'd0;
                3'd1: return 4'd6;
                3'd2: return 4'd5;
                3'd3: return 4'd7;
                3'd4: return 4'd4;
                3'd5: return f7[5] ? 4'd9 : 4'd8;
                3'd6: return 4'd3;
                default: return 4'd2;
            endcase
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] f3,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [2*XLEN+1:0] ea, eb, q, r;
        logic signed [4*XLEN+3:0] p;
        logic sa, sb;
        sa = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6);
        sb = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
        ea = sa ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
        eb = sb ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
        p = ea * eb;
        if (f3 == 3'd0) return p[XLEN-1:0];
        if (f3 < 3'd4)  return p[2*XLEN-1:XLEN];
        if (b == '0) begin
            q = '1;
            r = ea;
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
        return (f3 < 3'd6) ? q[XLEN-1:0] : r[XLEN-1:0];
    endfunction

    function automatic logic ref_req();
        return in_valid && aluop == 2'b10 && op5 && funct7 == 7'h01 && MDU_EN;
    endfunction

    bit              model_on = 1'b0;
    bit              m_busy, m_vld;
    int              m_left;
    logic [XLEN-1:0] m_res, m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_on = 1'b1;
            m_busy = 1'b0; m_vld = 1'b0; m_left = 0; m_res = '0;
        end else if (model_on) begin
            if (flush) begin
                m_busy = 1'b0; m_vld = 1'b0;
            end else if (m_vld) begin
                m_vld = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_vld = 1'b1; m_res = m_pend;
                end
            end else if (ref_req()) begin
                m_busy = 1'b1; m_left = XLEN + 1;
                m_pend = ref_mdu(funct3, rs1, rs2);
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("alu_ctrl", 64'(alu_ctrl), 64'(ref_ctrl(aluop, op5, funct3, funct7)));
            chk("illegal", 64'(illegal), 64'(ref_illegal(aluop, op5, funct3, funct7)));
            chk("stall", 64'(stall), 64'(!flush && (m_busy || (ref_req() && !m_vld))));
            chk("mdu_valid", 64'(mdu_valid), 64'(m_vld && !flush));
            chk("mdu_result", 64'(mdu_result), 64'(m_res));
        end
    end

    task automatic run_mop(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] exp, input string name);
        int n;
        bit seen;
        in_valid = 1'b1; aluop = 2'b10; op5 = 1'b1; funct7 = 7'h01;
        funct3 = f3; rs1 = a; rs2 = b;
        n = 0; seen = 1'b0;
        while (!seen && n < XLEN + 10) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (mdu_valid) seen = 1'b1;
        end
        chk({name, " valid"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(n), 64'(XLEN + 2));
        chk({name, " result"}, 64'(mdu_result), 64'(exp));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] pick();
        logic [XLEN-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 1;
            2: v = '1;
            3: v = {1'b1, {(XLEN-1){1'b0}}};
            4: v = {1'b0, {(XLEN-1){1'b1}}};
            5: v = XLEN'($urandom_range(0, 20));
            default: v = XLEN'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int vcount;
        logic [6:0] f7s [5];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h02; f7s[4] = 7'h7f;

        rst_n = 1'b0; in_valid = 1'b0; aluop = 2'b00; op5 = 1'b0; funct3 = 3'd0;
        funct7 = 7'h00; flush = 1'b0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset mdu_valid", 64'(mdu_valid), 64'd0);
        chk("reset mdu_result", 64'(mdu_result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Decode sweep with in_valid low so no M-op starts.
        for (int ao = 0; ao < 4; ao++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int k = 0; k < 5; k++)
                    for (int o = 0; o < 2; o++) begin
                        @(posedge clk); #1;
                        aluop = 2'(ao); funct3 = 3'(f3); funct7 = f7s[k]; op5 = 1'(o);
                    end
        @(posedge clk); #1;
        aluop = 2'b10; op5 = 1'b1; funct7 = 7'h02; funct3 = 3'd0;
        @(negedge clk);
        chk("lit illegal f7=02", 64'(illegal), 64'd1);
        chk("lit ctrl f7=02", 64'(alu_ctrl), 64'd0);
        @(posedge clk); #1;
        funct7 = 7'h20; funct3 = 3'd0;
        @(negedge clk);
        chk("lit sub", 64'(alu_ctrl), 64'd1);
        @(posedge clk); #1;
        funct3 = 3'd5;
        @(negedge clk);
        chk("lit sra", 64'(alu_ctrl), 64'd9);
        @(posedge clk); #1;
        funct3 = 3'd3;
        @(negedge clk);
        chk("lit illegal f7=20 sltu", 64'(illegal), 64'd1);
        @(posedge clk); #1;
        aluop = 2'b11; funct7 = 7'h00;
        @(negedge clk);
        chk("lit passb", 64'(alu_ctrl), 64'd10);
        @(posedge clk); #1;

        // Directed M-ops (second MUL follows the first back to back).
        run_mop(3'd0, 32'd7, -32'sd3, 32'hFFFFFFEB, "MUL 7*-3");
        run_mop(3'd0, 32'd9, 32'd9, 32'd81, "MUL 9*9");
        run_mop(3'd1, '1, '1, 32'h00000000, "MULH -1*-1");
        run_mop(3'd3, '1, '1, 32'hFFFFFFFE, "MULHU max*max");
        run_mop(3'd4, -32'sd7, 32'd2, 32'hFFFFFFFD, "DIV -7/2");
        run_mop(3'd6, -32'sd7, 32'd2, 32'hFFFFFFFF, "REM -7/2");
        run_mop(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "DIVU 5/0");
        run_mop(3'd7, 32'd5, 32'd0, 32'd5, "REMU 5/0");
        run_mop(3'd4, 32'h80000000, '1, 32'h80000000, "DIV ovf");
        run_mop(3'd6, 32'h80000000, '1, 32'd0, "REM ovf");

        // Flush part-way through CALC.
        in_valid = 1'b1; aluop = 2'b10; op5 = 1'b1; funct7 = 7'h01; funct3 = 3'd4;
        rs1 = 32'd100; rs2 = 32'd7;
        repeat (11) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk);
        chk("flush stall same cycle", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("after flush stall", 64'(stall), 64'd0);
        chk("after flush valid", 64'(mdu_valid), 64'd0);
        vcount = 0;
        repeat (XLEN + 5) begin
            @(negedge clk);
            if (mdu_valid) vcount++;
        end
        chk("no valid after flush", 64'(vcount), 64'd0);
        @(posedge clk); #1;
        run_mop(3'd4, 32'd100, 32'd7, 32'd14, "DIV after flush");

        // Reset during CALC.
        in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
        repeat (6) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mid reset result", 64'(mdu_result), 64'd0);
        chk("mid reset valid", 64'(mdu_valid), 64'd0);
        chk("mid reset stall", 64'(stall), 64'd0);
        @(posedge clk); #1;

        // Random traffic; the instruction is usually held while stalled, as the core would.
        for (int c = 0; c < 4000; c++) begin
            if (!stall || $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 9) < 5) begin
                    in_valid = 1'b1; aluop = 2'b10; op5 = 1'b1; funct7 = 7'h01;
                end else begin
                    in_valid = 1'($urandom_range(0, 1)); aluop = 2'($urandom_range(0, 3));
                    op5 = 1'($urandom_range(0, 1)); funct7 = f7s[$urandom_range(0, 4)];
                end
                funct3 = 3'($urandom_range(0, 7));
                rs1 = pick(); rs2 = pick();
            end
            flush = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
        repeat (XLEN + 5) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
